// File: rtl/led_pkg.sv
// Shared types and constants for the LED show sequencer and its prescaler.
package led_pkg;

    localparam int unsigned NUM_STEPS = 4;
    localparam int unsigned STEP_W    = $clog2(NUM_STEPS);
    localparam int unsigned DWELL_W   = 6;
    localparam int unsigned PRESCALE  = 16;
    localparam int unsigned PRESC_W   = $clog2(PRESCALE);
    localparam int unsigned CFG_W     = 8;

    // cfg_data layout: [7:6] mode, [5:0] dwell
    localparam int unsigned CFG_MODE_MSB  = 7;
    localparam int unsigned CFG_MODE_LSB  = 6;
    localparam int unsigned CFG_DWELL_MSB = 5;
    localparam int unsigned CFG_DWELL_LSB = 0;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_ALT   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HELD = 2'd2
    } state_e;

    typedef struct packed {
        mode_e                mode;
        logic [DWELL_W-1:0]   dwell;
    } step_t;

    function automatic step_t cfg_to_step(input logic [CFG_W-1:0] d);
        step_t s;
        s.mode  = mode_e'(d[CFG_MODE_MSB:CFG_MODE_LSB]);
        s.dwell = d[CFG_DWELL_MSB:CFG_DWELL_LSB];
        return s;
    endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Dwell-unit prescaler: counts advancing cycles and flags the wrap cycle.
module led_tick_prescaler
    import led_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic advance,
    output logic tick_c
);

    logic [PRESC_W-1:0] count_q;
    logic               at_top_c;

    assign at_top_c = (count_q == PRESC_W'(PRESCALE - 1));
    assign tick_c   = advance & ~clear & at_top_c;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (enable) begin
            if (clear) begin
                count_q <= '0;
            end else if (advance) begin
                count_q <= at_top_c ? '0 : count_q + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_show_sequencer.sv
// Step-table scheduler driving the LED pattern generator mode and enable.
module led_show_sequencer
    import led_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [STEP_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_data,
    input  logic [STEP_W-1:0] last_step,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              hold,
    output logic [1:0]        pattern_mode,
    output logic              gen_enable,
    output logic [STEP_W-1:0] step_idx,
    output logic              busy,
    output logic              done
);

    state_e              state_q, state_d;
    step_t               table_q [NUM_STEPS];
    mode_e               mode_q, mode_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [STEP_W-1:0]   last_q, last_d;
    logic [STEP_W-1:0]   next_idx;
    logic                gen_q, busy_q, done_q, done_d;
    logic                restart_c, advance_c, tick_c;

    // Start restarts from any state unless stop is also asserted
    assign restart_c = start & ~stop;
    assign advance_c = (state_q == ST_RUN) & ~stop & ~start & ~hold;

    led_tick_prescaler u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (enable),
        .clear   (restart_c),
        .advance (advance_c),
        .tick_c  (tick_c)
    );

    // Next-state and step sequencing
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        mode_d   = mode_q;
        dwell_d  = dwell_q;
        last_d   = last_q;
        done_d   = 1'b0;
        next_idx = step_q + STEP_W'(1);

        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
            step_d  = '0;
            mode_d  = table_q[0].mode;
            dwell_d = table_q[0].dwell;
            last_d  = last_step;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hold) begin
                        state_d = ST_HELD;
                    end else if (tick_c) begin
                        if (dwell_q != '0) begin
                            dwell_d = dwell_q - DWELL_W'(1);
                        end else if (step_q != last_q) begin
                            step_d  = next_idx;
                            mode_d  = table_q[next_idx].mode;
                            dwell_d = table_q[next_idx].dwell;
                        end else if (loop_en) begin
                            step_d  = '0;
                            mode_d  = table_q[0].mode;
                            dwell_d = table_q[0].dwell;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                ST_HELD: begin
                    if (!hold) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_COUNT;
            dwell_q <= '0;
            step_q  <= '0;
            last_q  <= '0;
            gen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                table_q[i] <= '0;
            end
        end else if (enable) begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
            last_q  <= last_d;
            gen_q   <= (state_d == ST_RUN);
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= done_d;
            if (cfg_we) begin
                table_q[cfg_addr] <= cfg_to_step(cfg_data);
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign pattern_mode = mode_q;
    assign gen_enable   = gen_q;
    assign step_idx     = step_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_led_show_sequencer.sv
// Bench for led_show_sequencer: vector table, directed sequences, random vs. model.
module tb_led_show_sequencer;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       reset_n, enable, cfg_we, loop_en, start, stop, hold;
    logic [1:0] cfg_addr, last_step;
    logic [7:0] cfg_data;
    logic [1:0] pattern_mode, step_idx;
    logic       gen_enable, busy, done;

    int checks = 0;
    int failures = 0;

    // Reference model: a step is a budget of (dwell+1)*P advancing cycles
    int m_mode, m_gen, m_idx, m_busy, m_done, m_rem, m_last;
    int t_mode [4];
    int t_dwell [4];

    led_show_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .last_step    (last_step),
        .loop_en      (loop_en),
        .start        (start),
        .stop         (stop),
        .hold         (hold),
        .pattern_mode (pattern_mode),
        .gen_enable   (gen_enable),
        .step_idx     (step_idx),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dut_out();
        return int'({pattern_mode, gen_enable, step_idx, busy, done});
    endfunction

    function automatic int model_out();
        return (m_mode << 5) | (m_gen << 4) | (m_idx << 2) | (m_busy << 1) | m_done;
    endfunction

    task automatic load_step(input int idx);
        m_idx  = idx;
        m_mode = t_mode[idx];
        m_rem  = (t_dwell[idx] + 1) * P;
    endtask

    task automatic model_update();
        if (!reset_n) begin
            m_mode = 0; m_gen = 0; m_idx = 0; m_busy = 0; m_done = 0; m_rem = 0; m_last = 0;
            for (int i = 0; i < 4; i++) begin
                t_mode[i] = 0;
                t_dwell[i] = 0;
            end
        end else if (!enable) begin
            m_done = 0;
        end else begin
            m_done = 0;
            if (stop) begin
                m_busy = 0;
                m_gen  = 0;
            end else if (start) begin
                load_step(0);
                m_busy = 1;
                m_gen  = 1;
                m_last = int'(last_step);
            end else if (m_busy == 1 && m_gen == 0) begin
                if (!hold) m_gen = 1;
            end else if (m_busy == 1) begin
                if (hold) begin
                    m_gen = 0;
                end else begin
                    m_rem--;
                    if (m_rem == 0) begin
                        if (m_idx != m_last) load_step(m_idx + 1);
                        else if (loop_en) load_step(0);
                        else begin
                            m_busy = 0;
                            m_gen  = 0;
                            m_done = 1;
                        end
                    end
                end
            end
            if (cfg_we) begin
                t_mode[cfg_addr]  = int'(cfg_data[7:6]);
                t_dwell[cfg_addr] = int'(cfg_data[5:0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        chk("model_outputs", dut_out(), model_out());
    endtask

    task automatic idle_inputs();
        reset_n = 1'b1; enable = 1'b1; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 8'd0;
        last_step = 2'd0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0;
    endtask

    task automatic write_entry(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    typedef struct {
        logic       rst_n, en, we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       st, sp, hd;
        logic [6:0] exp;   // {mode, gen_enable, step_idx, busy, done}
    } vec_t;

    vec_t vecs [11];

    initial begin
        int bad, cnt, found, snap;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h12};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h12};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 7'h02};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'hC0, 1'b0, 1'b0, 1'b1, 7'h02};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 7'h00};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'd0, 8'h40, 1'b0, 1'b0, 1'b0, 7'h00};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 7'h32};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 7'h20};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 7'h00};

        idle_inputs();
        reset_n = 1'b0;
        for (int i = 0; i < 11; i++) begin
            reset_n = vecs[i].rst_n; enable = vecs[i].en; cfg_we = vecs[i].we;
            cfg_addr = vecs[i].addr; cfg_data = vecs[i].data;
            start = vecs[i].st; stop = vecs[i].sp; hold = vecs[i].hd;
            tick();
            chk($sformatf("vec%0d", i), dut_out(), int'(vecs[i].exp));
        end
        idle_inputs();

        // Two-step one-shot program: mode 1 for 32, mode 3 for 16, then done
        write_entry(2'd0, 8'h41);
        write_entry(2'd1, 8'hC0);
        last_step = 2'd1;
        go();
        bad = 0;
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) tick();
            if (pattern_mode != 2'd1 || step_idx != 2'd0 || !gen_enable) bad++;
        end
        chk("oneshot_step0", bad, 0);
        bad = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (pattern_mode != 2'd3 || step_idx != 2'd1 || !gen_enable || done) bad++;
        end
        chk("oneshot_step1", bad, 0);
        tick();
        chk("oneshot_done", int'({done, busy, gen_enable, pattern_mode}), 5'b10011);
        tick();
        chk("oneshot_done_pulse", int'(done), 0);

        // Looping program: 1,3,1,3 with no done
        loop_en = 1'b1;
        go();
        bad = 0;
        for (int k = 1; k <= 96; k++) begin
            if (k > 1) tick();
            if (((k - 1) % 48) < 32) begin
                if (pattern_mode != 2'd1 || step_idx != 2'd0) bad++;
            end else begin
                if (pattern_mode != 2'd3 || step_idx != 2'd1) bad++;
            end
            if (done) bad++;
        end
        chk("loop_sequence", bad, 0);
        halt();
        loop_en = 1'b0;

        // Hold for 50 cycles after 10 cycles of step 0
        go();
        for (int k = 2; k <= 10; k++) tick();
        hold = 1'b1;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (gen_enable || !busy) bad++;
        end
        hold = 1'b0;
        chk("hold_gen_low", bad, 0);
        cnt = 9;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (step_idx == 2'd1) begin
                found = 1;
                break;
            end
            if (gen_enable) cnt++;
        end
        chk("hold_step_found", found, 1);
        chk("hold_run_cycles", cnt, 32);
        for (int k = 0; k < 20; k++) tick();

        // Stop and start together, then a clean restart with a full dwell
        go();
        for (int k = 0; k < 5; k++) tick();
        stop = 1'b1; start = 1'b1;
        tick();
        chk("stop_start_idle", int'({gen_enable, busy, done}), 0);
        stop = 1'b0; start = 1'b0;
        tick();
        chk("stop_start_nodone", int'(done), 0);
        go();
        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (step_idx != 2'd0) break;
            cnt++;
        end
        chk("restart_full_dwell", cnt, 32);
        halt();

        // Edit the active step: visible only on the next entry
        loop_en = 1'b1;
        go();
        for (int k = 0; k < 4; k++) tick();
        write_entry(2'd0, 8'h81);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (step_idx == 2'd1) break;
            if (pattern_mode != 2'd1) bad++;
            tick();
        end
        chk("edit_active_kept", bad, 0);
        found = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (step_idx == 2'd0) begin
                found = 1;
                break;
            end
        end
        chk("edit_reentry_found", found, 1);
        chk("edit_reentry_mode", int'(pattern_mode), 2);
        halt();
        loop_en = 1'b0;

        // Enable low freezes everything and blocks table writes
        go();
        for (int k = 0; k < 5; k++) tick();
        snap = dut_out();
        enable = 1'b0; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'h00;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dut_out() != snap) bad++;
        end
        chk("enable_freeze", bad, 0);
        enable = 1'b1; cfg_we = 1'b0;
        found = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (step_idx == 2'd1) begin
                found = 1;
                break;
            end
        end
        chk("enable_write_blocked", found == 1 ? int'(pattern_mode) : -1, 3);
        for (int k = 0; k < 20; k++) tick();

        // Randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            reset_n  = ($urandom_range(0, 499) != 0);
            enable   = ($urandom_range(0, 9) != 0);
            cfg_we   = ($urandom_range(0, 19) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_data = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 3))};
            if ($urandom_range(0, 49) == 0) last_step = 2'($urandom_range(0, 3));
            loop_en  = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 39) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            hold     = ($urandom_range(0, 5) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_show_sequencer.md
Name: led_show_sequencer

Overview:
Scheduler that drives the LED pattern generator's mode select and enable from a small programmable step table. Each step holds a 2-bit pattern mode and a dwell time in prescaled ticks. The block walks the table once or in a loop, and supports start, stop and hold. It sits between the user input pins and the pattern generator, replacing direct pin control of the mode bits.

Parameters:
NUM_STEPS, 4, number of table entries (power of two; index width STEP_W = log2(NUM_STEPS))
DWELL_W, 6, dwell field width in table entries
PRESCALE, 16, clock cycles per dwell unit; matches the generator's 16-cycle pattern update

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
enable  input  1  global enable; when low, all state, counters and outputs are frozen
cfg_we  input  1  table write strobe
cfg_addr  input  STEP_W  table entry to write
cfg_data  input  8  [7:6] mode, [5:0] dwell (N means N+1 units)
last_step  input  STEP_W  index of final step; latched on start
loop_en  input  1  1 = wrap to step 0 after last step; sampled when the last step ends
start  input  1  level; start or restart the program from step 0
stop  input  1  level; abort to IDLE
hold  input  1  level; freeze the running program
pattern_mode  output  2  mode to pattern generator
gen_enable  output  1  enable to pattern generator
step_idx  output  STEP_W  current step
busy  output  1  state is RUN or HELD
done  output  1  one-cycle pulse when a non-looping program completes

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - all table entries become mode 0, dwell 0
  - state IDLE
  - pattern_mode=0, gen_enable=0, step_idx=0, busy=0, done=0
  - prescaler=0, dwell counter=0, latched last_step=0
- enable=0: no register changes except table writes are also blocked. done is forced 0.
- Table writes: when cfg_we=1 and enable=1, the entry at cfg_addr updates at that edge. Writes are legal in any state. A step's mode and dwell are read only on entry to that step, so editing the active step takes effect on its next entry.
- States: IDLE, RUN, HELD. Input priority is stop > start > hold.
- IDLE:
  - start=1 -> RUN at the next edge: step_idx=0, pattern_mode=table[0].mode, dwell counter=table[0].dwell, prescaler=0, gen_enable=1, last_step latched.
  - Otherwise stay in IDLE with gen_enable=0.
  - pattern_mode keeps its last value.
- RUN:
  - stop=1 -> IDLE, gen_enable=0, no done pulse.
  - start=1 -> restart from step 0, same as the IDLE entry.
  - hold=1 -> HELD, gen_enable=0, counters frozen.
  - Otherwise the prescaler increments. On reaching PRESCALE-1 it wraps to 0. On that wrap, if the dwell counter is 0 the step ends; otherwise the dwell counter decrements.
- Step timing: a step lasts exactly (dwell+1)*PRESCALE cycles of RUN. With start sampled at edge t, step 0 is output for edges t+1 .. t+(d0+1)*PRESCALE, and step 1 appears at the following edge.
- Step end:
  - if step_idx != latched last_step: step_idx+1, load the new entry.
  - if step_idx == last_step and loop_en=1: step_idx=0, load entry 0.
  - if step_idx == last_step and loop_en=0: go to IDLE, gen_enable=0, done=1 for one cycle, pattern_mode holds the last mode.
- HELD:
  - stop -> IDLE.
  - start -> restart.
  - hold=0 -> RUN at the next edge, gen_enable=1, resuming with the exact remaining count.
- last_step greater than NUM_STEPS-1 cannot occur, because the field width is STEP_W.
- Simultaneous stop and start: stop wins.
- Reset asserted mid-program: full reset at that edge; the program does not resume.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package led_pkg holds:
  - mode constants MODE_COUNT=0, MODE_SCAN=1, MODE_LFSR=2, MODE_ALT=3
  - state encoding IDLE=0, RUN=1, HELD=2
  - cfg_data field positions
- Sub-module led_tick_prescaler: counter with clear and advance inputs, producing a one-cycle tick output. The table, step counter and FSM stay in the top module.

Test Plan:
- Reset with all inputs at 0 -> all outputs 0. Pulse start for one cycle -> gen_enable=1, step_idx=0, pattern_mode=0 on the next cycle.
- Program entries {0:(1,1), 1:(3,0)} with last_step=1, loop_en=0, then start -> mode 1 for 32 cycles, then mode 3 for 16 cycles. The next cycle shows done=1 for one cycle, busy=0 and gen_enable=0.
- Same program with loop_en=1 -> sequence 1,3,1,3... with step_idx wrapping 1->0. done never asserts.
- Start the program, raise hold after 10 cycles of step 0 for 50 cycles, then release -> step 0 lasts 32 RUN cycles total and gen_enable is 0 throughout the hold.
- Drive stop and start together in RUN -> IDLE with no done pulse. Then start alone -> restart at step 0 with a full dwell.
- Overwrite entry 0 to mode 2 while step 0 is active -> pattern_mode stays 1 until the next entry to step 0, then shows 2. Separately, hold enable=0 mid-step -> all outputs and counters frozen, and cfg_we writes are ignored.
